// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// IF stage of the 5-stage MIPS pipeline. Holds the PC, drives the
// combinational instruction memory, and loads the IF/ID pipeline register.
// Handles hazard stalls and jump/branch redirects. A redirect flushes the
// wrong-path fetch by inserting a bubble.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
// In the default build the counter ports are tied to zero.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 jump,
  input  logic [31:0]          jump_target,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_data,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc_plus4,
  output logic                 if_id_valid,
  output logic [CNT_WIDTH-1:0] fetch_count,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc_plus4;
  logic        r_if_id_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_redirect;
  logic        w_capture;
  logic        w_stall_hold;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_redirect   = jump | branch_taken;
  assign w_stall_hold = stall & ~w_redirect;
  assign w_capture    = ~w_redirect & ~stall;

  // Select the next PC: jump beats branch, and a redirect beats a stall.
  // Targets are forced to word alignment.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump) begin
      w_next_pc = {jump_target[31:2], 2'b00};
    end else if (branch_taken) begin
      w_next_pc = {branch_target[31:2], 2'b00};
    end else if (stall) begin
      w_next_pc = r_pc;
    end
  end

  // Update the PC and IF/ID register. Reset overrides everything.
  // A redirect flushes IF/ID, and a stall holds both the PC and IF/ID.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc             <= RESET_PC;
      r_if_id_instr    <= NOP_INSTR;
      r_if_id_pc_plus4 <= 32'h00000000;
      r_if_id_valid    <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (w_redirect) begin
        r_if_id_instr    <= NOP_INSTR;
        r_if_id_pc_plus4 <= 32'h00000000;
        r_if_id_valid    <= 1'b0;
      end else if (w_capture) begin
        r_if_id_instr    <= imem_data;
        r_if_id_pc_plus4 <= w_pc_plus4;
        r_if_id_valid    <= 1'b1;
      end
    end
  end

  assign imem_addr      = r_pc;
  assign if_id_instr    = r_if_id_instr;
  assign if_id_pc_plus4 = r_if_id_pc_plus4;
  assign if_id_valid    = r_if_id_valid;

`ifdef FETCH_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] r_fetch_count;
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic [CNT_WIDTH-1:0] r_flush_count;

  // Count captures, pure stalls and redirects. All counters wrap freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_capture)    r_fetch_count <= r_fetch_count + CNT_ONE;
      if (w_stall_hold) r_stall_count <= r_stall_count + CNT_ONE;
      if (w_redirect)   r_flush_count <= r_flush_count + CNT_ONE;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`else
  assign fetch_count = '0;
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit. A combinational
// instruction memory model answers imem_addr, and each scenario task
// checks the results against hand-computed values.
module tb_instruction_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic [31:0] ifIdInstr;
  logic [31:0] ifIdPcPlus4;
  logic        ifIdValid;
  logic [31:0] fetchCount;
  logic [31:0] stallCount;
  logic [31:0] flushCount;

  int vectorCount = 0;
  int missCount   = 0;

  instruction_fetch_unit #(
    .RESET_PC (32'h00000000),
    .NOP_INSTR(32'h00000000),
    .CNT_WIDTH(32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branchTaken),
    .branch_target (branchTarget),
    .jump          (jump),
    .jump_target   (jumpTarget),
    .imem_addr     (imemAddr),
    .imem_data     (imemData),
    .if_id_instr   (ifIdInstr),
    .if_id_pc_plus4(ifIdPcPlus4),
    .if_id_valid   (ifIdValid),
    .fetch_count   (fetchCount),
    .stall_count   (stallCount),
    .flush_count   (flushCount)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents. IM[0] and IM[1] are fixed words, the rest
  // of the low 256 bytes read as 0x2000_0000 | address, and everything
  // above reads as address ^ 0xA5A5_0000.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0)        return 32'hAC0D0000;
    else if (a == 32'h4)   return 32'h0232B020;
    else if (a < 32'h100)  return 32'h20000000 | a;
    else                   return a ^ 32'hA5A50000;
  endfunction

  always_comb imemData = memWord(imemAddr);

  function automatic logic [31:0] expCnt(input logic [31:0] n);
    return PERF ? n : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfId(input string name, input logic [31:0] eInstr,
                           input logic [31:0] ePc4, input logic eValid);
    vectorCount++;
    if ({ifIdInstr, ifIdPcPlus4, ifIdValid} !== {eInstr, ePc4, eValid}) begin
      missCount++;
      $display("[TB] FAIL %s ifid: got %h/%h/%b expected %h/%h/%b",
               name, ifIdInstr, ifIdPcPlus4, ifIdValid, eInstr, ePc4, eValid);
    end
  endtask

  task automatic checkAddr(input string name, input logic [31:0] eAddr);
    vectorCount++;
    if (imemAddr !== eAddr) begin
      missCount++;
      $display("[TB] FAIL %s imem_addr: got %h expected %h", name, imemAddr, eAddr);
    end
  endtask

  task automatic checkCounts(input string name, input logic [31:0] eFetch,
                             input logic [31:0] eStall, input logic [31:0] eFlush);
    vectorCount++;
    if ({fetchCount, stallCount, flushCount} !== {expCnt(eFetch), expCnt(eStall), expCnt(eFlush)}) begin
      missCount++;
      $display("[TB] FAIL %s counters: got %0d/%0d/%0d expected %0d/%0d/%0d",
               name, fetchCount, stallCount, flushCount,
               expCnt(eFetch), expCnt(eStall), expCnt(eFlush));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branchTaken = 1'b0; jump = 1'b0;
    branchTarget = 32'h0; jumpTarget = 32'h0;
    tick();
    tick();
    checkAddr("reset", 32'h0);
    checkIfId("reset", 32'h0, 32'h0, 1'b0);
    checkCounts("reset", 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    tick();
    checkIfId("seq_edge1", 32'hAC0D0000, 32'h4, 1'b1);
    checkAddr("seq_edge1", 32'h4);
    tick();
    checkIfId("seq_edge2", 32'h0232B020, 32'h8, 1'b1);
    checkAddr("seq_edge2", 32'h8);
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAddr("stall_hold", 32'h8);
      checkIfId("stall_hold", 32'h0232B020, 32'h8, 1'b1);
    end
    stall = 1'b0;
    tick();
    checkIfId("stall_release", 32'h20000008, 32'hC, 1'b1);
    checkAddr("stall_release", 32'hC);
    checkCounts("stall", 3, 3, 0);
  endtask

  task automatic test_branch();
    tick();
    checkIfId("pre_branch", 32'h2000000C, 32'h10, 1'b1);
    branchTaken = 1'b1; branchTarget = 32'h00000043;
    tick();
    checkAddr("branch_redirect", 32'h40);
    checkIfId("branch_flush", 32'h0, 32'h0, 1'b0);
    branchTaken = 1'b0;
    tick();
    checkIfId("branch_target", 32'h20000040, 32'h44, 1'b1);
    checkCounts("branch", 5, 3, 1);
  endtask

  task automatic test_back_to_back();
    jump = 1'b1; jumpTarget = 32'h100;
    branchTaken = 1'b1; branchTarget = 32'h200;
    stall = 1'b1;
    tick();
    checkAddr("jump_priority", 32'h100);
    checkIfId("jump_flush", 32'h0, 32'h0, 1'b0);
    jump = 1'b0; branchTaken = 1'b0; stall = 1'b0;
    tick();
    checkIfId("jump_target", 32'hA5A50100, 32'h104, 1'b1);
    checkCounts("jump", 6, 3, 2);
  endtask

  task automatic test_wrap();
    jump = 1'b1; jumpTarget = 32'hFFFFFFFF;
    tick();
    checkAddr("wrap_jump", 32'hFFFFFFFC);
    jump = 1'b0;
    tick();
    checkAddr("wrap_pc", 32'h0);
    checkIfId("wrap_fetch", 32'h5A5AFFFC, 32'h0, 1'b1);
    checkCounts("wrap", 7, 3, 3);
  endtask

  task automatic test_midrun_reset();
    tick();
    checkIfId("pre_reset", 32'hAC0D0000, 32'h4, 1'b1);
    reset = 1'b1; jump = 1'b1; jumpTarget = 32'h80; stall = 1'b1;
    tick();
    checkAddr("midrun_reset", 32'h0);
    checkIfId("midrun_reset", 32'h0, 32'h0, 1'b0);
    checkCounts("midrun_reset", 0, 0, 0);
    reset = 1'b0; jump = 1'b0; stall = 1'b0;
    tick();
    checkIfId("post_reset", 32'hAC0D0000, 32'h4, 1'b1);
    checkCounts("post_reset", 1, 0, 0);
  endtask

  // Run every scenario in order, then print the summary line.
  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_back_to_back();
    test_wrap();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
